note_judge: RTL and testbench

Per-lane hit judge for the falling-note display. It sits directly downstream of the per-lane note pattern generators: it consumes each lane's note vertical position and valid flag together with the player's push-buttons. It decides hit quality (perfect/good) or miss for every note crossing the hit bar, drives retire pulses back to the pattern stage, and maintains the score and combo counters for the HUD.

---
 rtl/rhythm_pkg.sv | 26 ++
 rtl/note_judge_if.sv | 28 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/note_judge.sv | 137 +++++++++++++
 tb/tb_note_judge.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rhythm_pkg.sv
// Shared constants and types for the falling-note hit judge.
// Holds lane count, hit/perfect window defaults, score weights, counter
// widths and the per-lane judge state type.
package rhythm_pkg;

  localparam int LANES_DEF      = 4;
  localparam int DEBOUNCE_DEF   = 250000;
  localparam int HIT_Y_MIN_DEF  = 442;
  localparam int HIT_Y_MAX_DEF  = 466;
  localparam int PERF_Y_MIN_DEF = 451;
  localparam int PERF_Y_MAX_DEF = 458;

  localparam int Y_W     = 10;
  localparam int SCORE_W = 16;
  localparam int COMBO_W = 8;

  localparam int PERF_WEIGHT = 2;
  localparam int GOOD_WEIGHT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_JUDGED = 2'd2
  } lane_state_t;

endpackage

// File: rtl/note_judge_if.sv
// Signal bundle between the note pattern stage / key inputs and the judge.
//   master: drives KEY, note_valid, note_y; receives judgments and HUD counters
//   slave : the judge itself
interface note_judge_if
  import rhythm_pkg::*;
#(
  parameter int LANES = LANES_DEF
);
  logic [LANES-1:0]     KEY;
  logic [LANES-1:0]     note_valid;
  logic [LANES*Y_W-1:0] note_y;
  logic [LANES-1:0]     hit_pulse;
  logic [LANES-1:0]     perfect_pulse;
  logic [LANES-1:0]     miss_pulse;
  logic [LANES-1:0]     note_clear;
  logic [SCORE_W-1:0]   score;
  logic [COMBO_W-1:0]   combo;

  modport master (
    output KEY, note_valid, note_y,
    input  hit_pulse, perfect_pulse, miss_pulse, note_clear, score, combo
  );

  modport slave (
    input  KEY, note_valid, note_y,
    output hit_pulse, perfect_pulse, miss_pulse, note_clear, score, combo
  );
endinterface

// File: rtl/key_debounce.sv
// One push-button conditioner: 2-flop synchronizer, inversion to active-high,
// stability debounce and a registered one-cycle press pulse.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   key_n : raw active-low button, asynchronous to clk
//   press : one-cycle pulse when the accepted level goes pressed
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             key_on;
  logic [CNT_W-1:0] cnt;

  assign key_on = ~sync2;

  // cnt tracks how many consecutive cycles key_on has disagreed with the
  // accepted level; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (key_on != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= key_on;
          cnt   <= '0;
          press <= key_on;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/note_judge.sv
// Per-lane hit judge for the falling-note display.
// Judges each note crossing the hit bar as perfect/good hit or miss, sends
// retire pulses back to the pattern stage and keeps saturating score/combo.
//   CLOCK_25 : pixel clock, the only clock
//   reset    : asynchronous active-high reset
//   nj       : note_judge_if slave (KEY, note_valid, note_y in; pulses,
//              note_clear, score, combo out)
//
// Lane FSM:
//   state     | meaning
//   ST_IDLE   | no note in the window yet
//   ST_ARMED  | note inside the window, awaiting press or exit
//   ST_JUDGED | note judged once, waiting for it to leave the window
module note_judge
  import rhythm_pkg::*;
#(
  parameter int LANES           = LANES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HIT_Y_MIN       = HIT_Y_MIN_DEF,
  parameter int HIT_Y_MAX       = HIT_Y_MAX_DEF,
  parameter int PERF_Y_MIN      = PERF_Y_MIN_DEF,
  parameter int PERF_Y_MAX      = PERF_Y_MAX_DEF
) (
  input logic         CLOCK_25,
  input logic         reset,
  note_judge_if.slave nj
);

  logic [LANES-1:0] press;
  logic [LANES-1:0] in_win;
  logic [LANES-1:0] past;
  logic [LANES-1:0] in_perf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [Y_W-1:0] y;
    assign y = nj.note_y[i*Y_W +: Y_W];

    assign in_win[i]  = nj.note_valid[i] && (y >= Y_W'(HIT_Y_MIN)) && (y <= Y_W'(HIT_Y_MAX));
    assign past[i]    = nj.note_valid[i] && (y > Y_W'(HIT_Y_MAX));
    assign in_perf[i] = (y >= Y_W'(PERF_Y_MIN)) && (y <= Y_W'(PERF_Y_MAX));

    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk   (CLOCK_25),
      .rst   (reset),
      .key_n (nj.KEY[i]),
      .press (press[i])
    );
  end

  lane_state_t        state [LANES];
  logic [LANES-1:0]   hit_nxt;
  logic [LANES-1:0]   perf_nxt;
  logic [LANES-1:0]   miss_nxt;
  logic [SCORE_W-1:0] pts;
  logic [COMBO_W-1:0] hits;
  logic [SCORE_W:0]   score_sum;
  logic [COMBO_W:0]   combo_sum;
  logic [SCORE_W-1:0] score_nxt;
  logic [COMBO_W-1:0] combo_nxt;

  logic [LANES-1:0]   hit_q;
  logic [LANES-1:0]   perf_q;
  logic [LANES-1:0]   miss_q;
  logic [SCORE_W-1:0] score_q;
  logic [COMBO_W-1:0] combo_q;

  // A hit needs the note still inside the window this cycle, so a press on
  // the exit cycle loses to the miss.
  always_comb begin
    hit_nxt  = '0;
    perf_nxt = '0;
    miss_nxt = '0;
    pts      = '0;
    hits     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state[i] == ST_ARMED) begin
        if (press[i] && in_win[i]) begin
          hit_nxt[i]  = 1'b1;
          perf_nxt[i] = in_perf[i];
        end else if (past[i] || !nj.note_valid[i]) begin
          miss_nxt[i] = 1'b1;
        end
      end
      if (perf_nxt[i]) begin
        pts = pts + SCORE_W'(PERF_WEIGHT);
      end else if (hit_nxt[i]) begin
        pts = pts + SCORE_W'(GOOD_WEIGHT);
      end
      hits = hits + COMBO_W'(hit_nxt[i]);
    end
    score_sum = {1'b0, score_q} + {1'b0, pts};
    combo_sum = {1'b0, combo_q} + {1'b0, hits};
    score_nxt = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    if (|miss_nxt) begin
      combo_nxt = '0;
    end else begin
      combo_nxt = combo_sum[COMBO_W] ? {COMBO_W{1'b1}} : combo_sum[COMBO_W-1:0];
    end
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        state[i] <= ST_IDLE;
      end
      hit_q   <= '0;
      perf_q  <= '0;
      miss_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        case (state[i])
          ST_IDLE:   if (in_win[i]) state[i] <= ST_ARMED;
          ST_ARMED:  if (hit_nxt[i] || miss_nxt[i]) state[i] <= ST_JUDGED;
          ST_JUDGED: if (!in_win[i]) state[i] <= ST_IDLE;
          default:   state[i] <= ST_IDLE;
        endcase
      end
      hit_q   <= hit_nxt;
      perf_q  <= perf_nxt;
      miss_q  <= miss_nxt;
      score_q <= score_nxt;
      combo_q <= combo_nxt;
    end
  end

  assign nj.hit_pulse     = hit_q;
  assign nj.perfect_pulse = perf_q;
  assign nj.miss_pulse    = miss_q;
  assign nj.note_clear    = hit_q;
  assign nj.score         = score_q;
  assign nj.combo         = combo_q;

endmodule

// File: tb/tb_note_judge.sv
module tb_note_judge;
  import rhythm_pkg::*;

  localparam int L = 4;
  localparam int D = 4;

  logic CLOCK_25 = 1'b0;
  logic reset    = 1'b1;

  always #5 CLOCK_25 = ~CLOCK_25;

  note_judge_if #(.LANES(L)) nj ();

  note_judge #(
    .LANES(L),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK_25 (CLOCK_25),
    .reset    (reset),
    .nj       (nj)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: the note's judgment status per lane, the button as
  // the synchronized history plus an accepted level, and score/combo as ints.
  bit m_live [L];
  bit m_done [L];
  bit m_s1   [L];
  bit m_s2   [L];
  bit m_lvl  [L];
  int m_cnt  [L];
  bit m_press[L];
  int m_score;
  int m_combo;
  logic [L-1:0] e_hit, e_perf, e_miss;

  int obs_hit [L];
  int obs_perf[L];
  int obs_miss[L];
  int obs_clr [L];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int y;
    int perfs, goods, hits, misses;
    bit v, inw, pst;
    e_hit  = '0;
    e_perf = '0;
    e_miss = '0;
    if (reset) begin
      for (int l = 0; l < L; l++) begin
        m_live[l] = 0; m_done[l] = 0; m_s1[l] = 0; m_s2[l] = 0;
        m_lvl[l] = 0; m_cnt[l] = 0; m_press[l] = 0;
      end
      m_score = 0;
      m_combo = 0;
      return;
    end
    perfs = 0; goods = 0; hits = 0; misses = 0;
    for (int l = 0; l < L; l++) begin
      y   = int'(nj.note_y[l*10 +: 10]);
      v   = nj.note_valid[l];
      inw = v && y >= 442 && y <= 466;
      pst = v && y > 466;
      if (m_done[l]) begin
        if (!inw) m_done[l] = 0;
      end else if (m_live[l]) begin
        if (m_press[l] && inw) begin
          e_hit[l] = 1'b1;
          hits++;
          if (y >= 451 && y <= 458) begin
            e_perf[l] = 1'b1;
            perfs++;
          end else begin
            goods++;
          end
          m_live[l] = 0;
          m_done[l] = 1;
        end else if (pst || !v) begin
          e_miss[l] = 1'b1;
          misses++;
          m_live[l] = 0;
          m_done[l] = 1;
        end
      end else if (inw) begin
        m_live[l] = 1;
      end
      // button: level accepted after D consecutive disagreeing samples
      if (m_s2[l] != m_lvl[l]) begin
        m_cnt[l]++;
        if (m_cnt[l] == D) begin
          m_lvl[l]   = m_s2[l];
          m_cnt[l]   = 0;
          m_press[l] = m_s2[l];
        end else begin
          m_press[l] = 0;
        end
      end else begin
        m_cnt[l]   = 0;
        m_press[l] = 0;
      end
      m_s2[l] = m_s1[l];
      m_s1[l] = !nj.KEY[l];
    end
    m_score = m_score + 2 * perfs + goods;
    if (m_score > 65535) m_score = 65535;
    if (misses > 0) m_combo = 0;
    else begin
      m_combo = m_combo + hits;
      if (m_combo > 255) m_combo = 255;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_25);
      #2;
      model_step();
      chk("hit_pulse",     nj.hit_pulse,     e_hit);
      chk("perfect_pulse", nj.perfect_pulse, e_perf);
      chk("miss_pulse",    nj.miss_pulse,    e_miss);
      chk("note_clear",    nj.note_clear,    e_hit);
      chk("score",         nj.score,         m_score);
      chk("combo",         nj.combo,         m_combo);
      for (int l = 0; l < L; l++) begin
        obs_hit[l]  += int'(nj.hit_pulse[l]);
        obs_perf[l] += int'(nj.perfect_pulse[l]);
        obs_miss[l] += int'(nj.miss_pulse[l]);
        obs_clr[l]  += int'(nj.note_clear[l]);
      end
    end
  endtask

  task automatic set_y(input int lane, input int y);
    nj.note_y[lane*10 +: 10] = 10'(y);
  endtask

  task automatic press_lane(input int lane, input int hold, input int after);
    nj.KEY[lane] = 1'b0;
    tick(hold);
    nj.KEY[lane] = 1'b1;
    tick(after);
  endtask

  task automatic do_round(input logic [L-1:0] act);
    nj.note_valid = act;
    nj.KEY = '0;
    tick(4);
    nj.KEY = '1;
    tick(3);
    nj.note_valid = '0;
    tick(1);
  endtask

  int h0, p0, c0, m1, m2, h3, h_all;

  initial begin
    for (int l = 0; l < L; l++) begin
      obs_hit[l] = 0; obs_perf[l] = 0; obs_miss[l] = 0; obs_clr[l] = 0;
    end
    nj.KEY        = '1;
    nj.note_valid = '0;
    nj.note_y     = '0;
    reset = 1'b1;
    tick(3);
    chk("reset_score", nj.score, 0);
    chk("reset_combo", nj.combo, 0);
    chk("reset_pulses", {nj.hit_pulse, nj.miss_pulse, nj.perfect_pulse}, 0);
    reset = 1'b0;
    tick(2);

    // 1: perfect hit on lane 0
    h0 = obs_hit[0]; p0 = obs_perf[0]; c0 = obs_clr[0];
    set_y(0, 454);
    nj.note_valid[0] = 1'b1;
    tick(2);
    press_lane(0, 6, 8);
    chk("t1_hits",  obs_hit[0] - h0, 1);
    chk("t1_perf",  obs_perf[0] - p0, 1);
    chk("t1_clear", obs_clr[0] - c0, 1);
    chk("t1_score", nj.score, 2);
    chk("t1_combo", nj.combo, 1);
    nj.note_valid[0] = 1'b0;
    tick(2);

    // 2: good hit on lane 1, then exit without a miss
    h0 = obs_hit[1]; p0 = obs_perf[1]; m1 = obs_miss[1];
    set_y(1, 444);
    nj.note_valid[1] = 1'b1;
    tick(2);
    press_lane(1, 6, 8);
    chk("t2_score", nj.score, 3);
    chk("t2_combo", nj.combo, 2);
    set_y(1, 470);
    tick(3);
    chk("t2_hits", obs_hit[1] - h0, 1);
    chk("t2_perf", obs_perf[1] - p0, 0);
    chk("t2_miss", obs_miss[1] - m1, 0);
    nj.note_valid[1] = 1'b0;
    tick(2);

    // build combo to 5 with good hits
    for (int k = 0; k < 3; k++) begin
      set_y(0, 445);
      nj.note_valid[0] = 1'b1;
      tick(2);
      press_lane(0, 6, 8);
      nj.note_valid[0] = 1'b0;
      tick(2);
    end
    chk("pre3_score", nj.score, 6);
    chk("pre3_combo", nj.combo, 5);

    // 3: lane 2 passes through the window untouched
    m2 = obs_miss[2];
    set_y(2, 440);
    nj.note_valid[2] = 1'b1;
    tick(3);
    set_y(2, 450);
    tick(3);
    set_y(2, 467);
    tick(1);
    chk("t3_miss_now", nj.miss_pulse[2], 1);
    tick(1);
    chk("t3_miss", obs_miss[2] - m2, 1);
    chk("t3_combo", nj.combo, 0);
    chk("t3_score", nj.score, 6);
    nj.note_valid[2] = 1'b0;
    tick(2);

    // 4: bouncing key on lane 3
    h3 = obs_hit[3];
    set_y(3, 455);
    nj.note_valid[3] = 1'b1;
    tick(2);
    for (int k = 0; k < 10; k++) begin
      nj.KEY[3] = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    press_lane(3, 8, 8);
    chk("t4_hits", obs_hit[3] - h3, 1);
    chk("t4_score", nj.score, 8);
    chk("t4_combo", nj.combo, 1);
    nj.note_valid[3] = 1'b0;
    tick(2);

    // press with no note is ignored
    press_lane(2, 6, 8);
    chk("idle_score", nj.score, 8);
    chk("idle_combo", nj.combo, 1);

    // 5: same-cycle perfect hit (lane 0) and miss (lane 1)
    set_y(0, 455);
    set_y(1, 460);
    nj.note_valid[1:0] = 2'b11;
    tick(2);
    nj.KEY[0] = 1'b0;
    tick(6);
    set_y(1, 470);
    tick(1);
    chk("t5_hit_now",  nj.hit_pulse[0], 1);
    chk("t5_miss_now", nj.miss_pulse[1], 1);
    tick(3);
    nj.KEY[0] = 1'b1;
    tick(8);
    chk("t5_score", nj.score, 10);
    chk("t5_combo", nj.combo, 0);
    nj.note_valid = '0;
    tick(2);

    // 6: saturation
    reset = 1'b1;
    tick(2);
    chk("t6_reset_score", nj.score, 0);
    reset = 1'b0;
    tick(1);
    for (int l = 0; l < L; l++) set_y(l, 455);
    for (int r = 0; r < 8191; r++) do_round('1);
    chk("t6_ramp_score", nj.score, 65528);
    chk("t6_ramp_combo", nj.combo, 255);
    do_round(4'b0111);
    chk("t6_pre_score", nj.score, 65534);
    chk("t6_pre_combo", nj.combo, 255);
    do_round(4'b0001);
    do_round(4'b0001);
    chk("t6_sat_score", nj.score, 65535);
    chk("t6_sat_combo", nj.combo, 255);

    // reset while a note is armed and a press is about to land
    set_y(0, 455);
    nj.note_valid = 4'b0001;
    tick(2);
    nj.KEY[0] = 1'b0;
    tick(5);
    reset = 1'b1;
    #1;
    chk("rst_score", nj.score, 0);
    chk("rst_combo", nj.combo, 0);
    chk("rst_pulses", {nj.hit_pulse, nj.miss_pulse, nj.perfect_pulse, nj.note_clear}, 0);
    h_all = obs_hit[0] + obs_hit[1] + obs_hit[2] + obs_hit[3]
          + obs_miss[0] + obs_miss[1] + obs_miss[2] + obs_miss[3];
    nj.KEY[0] = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("rst_no_pulse", obs_hit[0] + obs_hit[1] + obs_hit[2] + obs_hit[3]
          + obs_miss[0] + obs_miss[1] + obs_miss[2] + obs_miss[3] - h_all, 0);
    press_lane(0, 6, 8);
    chk("post_rst_score", nj.score, 2);
    chk("post_rst_combo", nj.combo, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
